// File: rtl/turbo_encode_pkg.sv
// Shared constants, types and GF(2) helpers for the streaming turbo encoder.
// The RSC state holds past feedback values: bit 0 = a_{k-1}, bit M-1 = a_{k-M}.
package turbo_encode_pkg;
   localparam int N         = 8;
   localparam int NOUT      = 2;
   localparam int TAIL_BITS = 2;
   localparam int STATES    = 4;
   localparam int P         = 3;
   localparam int M         = $clog2(STATES);
   localparam int R         = 1 + 2*(NOUT-1);
   localparam int COLS      = N + TAIL_BITS;
   localparam int IW        = $clog2(N);
   localparam int KW        = $clog2(COLS);

   localparam logic [M:0] RECURSIVE = (M+1)'(7);
   localparam logic [M:0] POLY [2]  = '{(M+1)'(5), (M+1)'(7)};

   typedef logic [M-1:0]  rsc_state_t;
   typedef logic [KW-1:0] col_t;
   typedef logic [IW-1:0] idx_t;
   typedef enum logic [1:0] {ST_IDLE, ST_SYS, ST_PAR1, ST_PAR2} phase_t;

   function automatic idx_t interleave_idx(input col_t k);
      return idx_t'((int'(k) * P) % N);
   endfunction

   // Feedback taps excluding D^0; feeding this back as input forces a_k = 0.
   function automatic logic rsc_term_bit(input rsc_state_t s);
      logic fb;
      fb = 1'b0;
      for (int j = 1; j <= M; j++) fb = fb ^ (RECURSIVE[M-j] & s[j-1]);
      return fb;
   endfunction

   function automatic rsc_state_t rsc_next(input rsc_state_t s, input logic x);
      rsc_state_t n;
      n    = s << 1;
      n[0] = x ^ rsc_term_bit(s);
      return n;
   endfunction

   function automatic logic rsc_parity(input rsc_state_t s, input logic x);
      logic a;
      logic p;
      a = x ^ rsc_term_bit(s);
      p = POLY[0][M] & a;
      for (int j = 1; j <= M; j++) p = p ^ (POLY[0][M-j] & s[j-1]);
      return p;
   endfunction
endpackage

// File: rtl/turbo_encode_if.sv
// Serial information-bit input and encoded-bit output handshake bundle.
interface turbo_encode_if;
   logic in_valid;
   logic single_x;
   logic in_ready;
   logic out_valid;
   logic single_y;
   logic out_first;

   modport master (output in_valid, single_x, input in_ready, out_valid, single_y, out_first);
   modport slave  (input in_valid, single_x, output in_ready, out_valid, single_y, out_first);
endinterface

// File: rtl/turbo_encode_core.sv
// RSC encoder core: clear, step or terminate each cycle; parity and applied input are combinational.
// The applied input o_sys is x, or the termination bit when i_term is high.
module rsc_encode_core
   import turbo_encode_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_step,
   input  logic i_term,
   input  logic i_x,
   output logic o_sys,
   output logic o_par
);
   rsc_state_t r_state;

   assign o_sys = i_term ? rsc_term_bit(r_state) : i_x;
   assign o_par = rsc_parity(r_state, o_sys);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_state <= '0;
      else if (i_clr)  r_state <= '0;
      else if (i_step) r_state <= rsc_next(r_state, o_sys);
   end
endmodule

// File: rtl/turbo_encode_top.sv
// Ping-pong turbo encoder: N bits in, 3 rows of N+TAIL_BITS bits out; first bit one edge after load.
// in_ready drops while the load buffer is full and rises again at handover to the engine.
module turbo_encode_top
   import turbo_encode_pkg::*;
(
   input logic           clk,
   input logic           reset,
   turbo_encode_if.slave bus
);
   logic [N-1:0]    r_load_buf;
   logic [N-1:0]    r_work_buf;
   logic [COLS-1:0] r_p1_buf;
   idx_t            r_load_idx;
   logic            r_load_full;
   phase_t          r_state;
   phase_t          w_state_nxt;
   col_t            r_k;
   col_t            w_k_nxt;
   logic            w_accept;
   logic            w_last;
   logic            w_tail;
   logic            w_handover;
   logic            w_clr;
   logic            w_step;
   logic            w_term;
   logic            w_cx;
   logic            w_y;
   logic            w_sys;
   logic            w_par;

   assign w_accept   = bus.in_valid && !r_load_full;
   assign w_last     = (r_k == col_t'(COLS-1));
   assign w_tail     = (r_k >= col_t'(N));
   // Handover also fires on the final PAR2 bit so consecutive blocks stream gap-free.
   assign w_handover = r_load_full && ((r_state == ST_IDLE) || ((r_state == ST_PAR2) && w_last));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load_buf  <= '0;
         r_work_buf  <= '0;
         r_load_idx  <= '0;
         r_load_full <= 1'b0;
      end else begin
         if (w_handover) begin
            r_work_buf  <= r_load_buf;
            r_load_full <= 1'b0;
         end
         if (w_accept) begin
            r_load_buf[r_load_idx] <= bus.single_x;
            if (r_load_idx == idx_t'(N-1)) begin
               r_load_idx  <= '0;
               r_load_full <= 1'b1;
            end else begin
               r_load_idx <= r_load_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_k      <= '0;
         r_p1_buf <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         if (r_state == ST_SYS) r_p1_buf[r_k] <= w_par;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = w_last ? '0 : r_k + 1'b1;
      w_clr       = 1'b0;
      w_step      = 1'b0;
      w_term      = 1'b0;
      w_cx        = 1'b0;
      w_y         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_k_nxt = '0;
            if (w_handover) begin
               w_state_nxt = ST_SYS;
               w_clr       = 1'b1;
            end
         end
         ST_SYS: begin
            w_cx   = r_work_buf[r_k[IW-1:0]];
            w_term = w_tail;
            w_step = 1'b1;
            w_y    = w_sys;
            if (w_last) w_state_nxt = ST_PAR1;
         end
         ST_PAR1: begin
            w_y = r_p1_buf[r_k];
            if (w_last) begin
               w_state_nxt = ST_PAR2;
               w_clr       = 1'b1;
            end
         end
         ST_PAR2: begin
            w_cx   = r_work_buf[interleave_idx(r_k)];
            w_term = w_tail;
            w_step = 1'b1;
            w_y    = w_par;
            if (w_last) begin
               w_state_nxt = w_handover ? ST_SYS : ST_IDLE;
               w_clr       = w_handover;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_k_nxt     = '0;
         end
      endcase
   end

   rsc_encode_core u_core (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_clr),
      .i_step (w_step),
      .i_term (w_term),
      .i_x    (w_cx),
      .o_sys  (w_sys),
      .o_par  (w_par)
   );

   assign bus.in_ready  = !r_load_full;
   assign bus.out_valid = (r_state != ST_IDLE);
   assign bus.out_first = (r_state == ST_SYS) && (r_k == '0);
   assign bus.single_y  = w_y;
endmodule

// File: tb/tb_turbo_encode_top.sv
// Directed and randomized bench for turbo_encode_top against a recurrence-level reference model.
module tb_turbo_encode_top;
   localparam int TN    = 8;
   localparam int TM    = 2;
   localparam int TCOLS = 10;
   localparam int TBLK  = 30;
   localparam int TREC  = 7;
   localparam int TFF   = 5;
   localparam int TP    = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   logic cap_q [$];
   logic first_q [$];
   int   cyc_q [$];
   logic exp_blk [TBLK];

   turbo_encode_if bus ();

   turbo_encode_top dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         cap_q.push_back(bus.single_y);
         first_q.push_back(bus.out_first);
         cyc_q.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cap(input int target, input string tag);
      int c;
      c = 0;
      while (cap_q.size() < target && c < 300) begin
         tick();
         c++;
      end
      chk(tag, 32'(cap_q.size() >= target), 32'd1);
   endtask

   // gap_mode: 0 = back-to-back, 1 = idle cycle after each bit, 2 = random idle cycles
   task automatic send_block(input logic [TN-1:0] x, input int gap_mode, output int t_last);
      int c;
      t_last = 0;
      for (int i = 0; i < TN; i++) begin
         c = 0;
         while (bus.in_ready !== 1'b1 && c < 100) begin
            tick();
            c++;
         end
         chk($sformatf("send_rdy_b%0d", i), 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b1;
         bus.single_x = x[i];
         tick();
         t_last       = cyc;
         bus.in_valid = 1'b0;
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(1) == 1)) tick();
      end
   endtask

   // a[k+TM] holds a_k; a[0..TM-1] is the zero starting history.
   function automatic void rsc_model(input logic u[TN], output logic sys[TCOLS], output logic par[TCOLS]);
      int a [TCOLS+TM];
      int fb;
      int p;
      for (int i = 0; i < TCOLS + TM; i++) a[i] = 0;
      for (int k = 0; k < TCOLS; k++) begin
         fb = 0;
         for (int j = 1; j <= TM; j++) fb = fb ^ (((TREC >> (TM - j)) & 1) * a[k+TM-j]);
         sys[k]   = (k < TN) ? u[k] : 1'(fb);
         a[k+TM]  = int'(sys[k]) ^ fb;
         p = 0;
         for (int j = 0; j <= TM; j++) p = p ^ (((TFF >> (TM - j)) & 1) * a[k+TM-j]);
         par[k] = 1'(p);
      end
   endfunction

   function automatic void fill_exp(input logic [TN-1:0] x);
      logic u1 [TN];
      logic u2 [TN];
      logic s1 [TCOLS];
      logic p1 [TCOLS];
      logic s2 [TCOLS];
      logic p2 [TCOLS];
      for (int k = 0; k < TN; k++) begin
         u1[k] = x[k];
         u2[k] = x[(k * TP) % TN];
      end
      rsc_model(u1, s1, p1);
      rsc_model(u2, s2, p2);
      for (int k = 0; k < TCOLS; k++) begin
         exp_blk[k]           = s1[k];
         exp_blk[TCOLS + k]   = p1[k];
         exp_blk[2*TCOLS + k] = p2[k];
      end
   endfunction

   task automatic check_block(input int base, input string tag);
      for (int i = 0; i < TBLK; i++) begin
         chk($sformatf("%s_y%0d", tag, i), 32'(cap_q[base+i]), 32'(exp_blk[i]));
         chk($sformatf("%s_first%0d", tag, i), 32'(first_q[base+i]), 32'(i == 0));
         chk($sformatf("%s_contig%0d", tag, i), 32'(cyc_q[base+i] - cyc_q[base]), 32'(i));
      end
   endtask

   task automatic check_impulse_const(input int base, input string tag);
      logic [0:TBLK-1] imp_ref;
      imp_ref = 30'b1000000001_1110110111_1110110111;
      for (int i = 0; i < TBLK; i++)
         chk($sformatf("%s_const%0d", tag, i), 32'(cap_q[base+i]), 32'(imp_ref[i]));
   endtask

   initial begin
      int base;
      int t_last;
      int sz;
      logic [TN-1:0] xa;
      logic [TN-1:0] xb;

      bus.in_valid = 1'b0;
      bus.single_x = 1'b0;
      reset        = 1'b1;
      repeat (5) tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_single_y", 32'(bus.single_y), 32'd0);
      chk("rst_out_first", 32'(bus.out_first), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      reset = 1'b0;
      repeat (8) tick();
      chk("idle_no_valid", 32'(cap_q.size()), 32'd0);

      // all-zero block
      base = cap_q.size();
      send_block(8'h00, 0, t_last);
      fill_exp(8'h00);
      wait_cap(base + TBLK, "zero_wait");
      chk("zero_latency", 32'(cyc_q[base]), 32'(t_last + 1));
      check_block(base, "zero");
      repeat (6) tick();
      chk("zero_count", 32'(cap_q.size()), 32'(base + TBLK));

      // impulse against fixed vectors
      base = cap_q.size();
      send_block(8'b0000_0001, 0, t_last);
      fill_exp(8'b0000_0001);
      wait_cap(base + TBLK, "imp_wait");
      chk("imp_latency", 32'(cyc_q[base]), 32'(t_last + 1));
      check_impulse_const(base, "imp");
      check_block(base, "imp");

      // pattern 1,1,1,0,0,0,1,1 with gapped in_valid
      base = cap_q.size();
      send_block(8'b1100_0111, 1, t_last);
      fill_exp(8'b1100_0111);
      wait_cap(base + TBLK, "pat_wait");
      chk("pat_latency", 32'(cyc_q[base]), 32'(t_last + 1));
      check_block(base, "pat");

      // back-to-back random blocks
      repeat (4) tick();
      xa   = 8'($urandom);
      xb   = 8'($urandom);
      base = cap_q.size();
      send_block(xa, 0, t_last);
      send_block(xb, 2, t_last);
      tick();
      chk("b2b_rdy_low", 32'(bus.in_ready), 32'd0);
      wait_cap(base + TBLK, "b2b_waitA");
      chk("b2b_rdy_hold", 32'(bus.in_ready), 32'd0);
      tick();
      chk("b2b_rdy_release", 32'(bus.in_ready), 32'd1);
      wait_cap(base + 2*TBLK, "b2b_waitB");
      fill_exp(xa);
      check_block(base, "b2bA");
      fill_exp(xb);
      check_block(base + TBLK, "b2bB");
      chk("b2b_no_gap", 32'(cyc_q[base+TBLK] - cyc_q[base+TBLK-1]), 32'd1);
      repeat (6) tick();
      chk("b2b_count", 32'(cap_q.size()), 32'(base + 2*TBLK));

      // mid-stream reset at output bit 12
      base = cap_q.size();
      send_block(8'b0000_0001, 0, t_last);
      wait_cap(base + 13, "mr_wait");
      reset = 1'b1;
      #1;
      chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mr_single_y", 32'(bus.single_y), 32'd0);
      chk("mr_out_first", 32'(bus.out_first), 32'd0);
      repeat (3) tick();
      chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
      reset = 1'b0;
      sz = cap_q.size();
      repeat (40) tick();
      chk("mr_no_valid", 32'(cap_q.size()), 32'(sz));
      base = cap_q.size();
      send_block(8'b0000_0001, 0, t_last);
      fill_exp(8'b0000_0001);
      wait_cap(base + TBLK, "mr_imp_wait");
      chk("mr_imp_latency", 32'(cyc_q[base]), 32'(t_last + 1));
      check_impulse_const(base, "mr_imp");
      check_block(base, "mr_imp");

      // isolated random blocks with random input gaps
      for (int r = 0; r < 3; r++) begin
         repeat (3) tick();
         xa   = 8'($urandom);
         base = cap_q.size();
         send_block(xa, 2, t_last);
         fill_exp(xa);
         wait_cap(base + TBLK, $sformatf("rnd%0d_wait", r));
         chk($sformatf("rnd%0d_latency", r), 32'(cyc_q[base]), 32'(t_last + 1));
         check_block(base, $sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
